ours_axi4_ar_demux_buf: RTL and testbench

OURS_AXI4_AR_DEMUX_BUF -- requirements
Module: ours_axi4_ar_demux_buf

---
 rtl/ours_axi4_ar_demux_buf.sv | 126 ++++++++++++
 tb/tb_ours_axi4_ar_demux_buf.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ours_axi4_ar_demux_buf.sv
// ours_axi4_ar_demux_buf: 2-deep AR buffer routing to N targets with per-target outstanding limits.
// Define OURS_AXI4_AR_DEMUX_STRICT_ORDER_EN to force in-order R returns across targets.
module ours_axi4_ar_demux_buf #(
    parameter int N_OUTPUT        = 2,
    parameter int WIDTH           = 32,
    parameter int SEL_POSITION    = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           slave_arvld,
    input  logic [WIDTH-1:0]               slave_ar,
    output logic                           slave_arrdy,
    output logic [N_OUTPUT-1:0]            master_arvld,
    output logic [N_OUTPUT-1:0][WIDTH-1:0] master_ar,
    input  logic [N_OUTPUT-1:0]            master_arrdy,
    input  logic [N_OUTPUT-1:0]            r_done,
    output logic                           clk_en
);
    localparam int SW = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [SW:0] N_LIM = (SW + 1)'(N_OUTPUT);

    logic [WIDTH-1:0]    mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic [CW-1:0]       cnt [N_OUTPUT];

    logic [WIDTH-1:0]    head;
    logic [SW-1:0]       sel;
    logic [SW-1:0]       tgt;
    logic                push;
    logic                pop;
    logic                limit_blk;
    logic                order_blk;
    logic                issue;
    logic                any_cnt;
    logic [N_OUTPUT-1:0] inc;
    logic [N_OUTPUT-1:0] dec;

    assign head = mem[rd_ptr];
    assign sel  = head[SEL_POSITION +: SW];

    // Out-of-range selects fold onto the last target.
    always_comb begin
        tgt = sel;
        if ({1'b0, sel} >= N_LIM)
            tgt = SW'(N_OUTPUT - 1);
    end

`ifdef OURS_AXI4_AR_DEMUX_STRICT_ORDER_EN
    logic [SW-1:0] last_tgt;

    always_ff @(posedge clk) begin
        if (rst)
            last_tgt <= '0;
        else if (pop)
            last_tgt <= tgt;
    end

    assign order_blk = (tgt != last_tgt) && (cnt[last_tgt] != '0);
`else
    assign order_blk = 1'b0;
`endif

    // A same-cycle r_done frees the slot, so a full target may still issue.
    assign limit_blk   = (cnt[tgt] == CNT_MAX) && !r_done[tgt];
    assign issue       = !rst && (count != 2'd0) && !limit_blk && !order_blk;
    assign pop         = issue && master_arrdy[tgt];
    assign slave_arrdy = !rst && (count != 2'd2);
    assign push        = slave_arvld && slave_arrdy;

    always_comb begin
        master_arvld      = '0;
        master_arvld[tgt] = issue;
        for (int i = 0; i < N_OUTPUT; i++)
            master_ar[i] = head;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= slave_ar;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_comb begin
        any_cnt = 1'b0;
        for (int i = 0; i < N_OUTPUT; i++) begin
            inc[i]  = pop && (tgt == SW'(i));
            dec[i]  = r_done[i] && (cnt[i] != '0);
            any_cnt = any_cnt | (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_OUTPUT; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_OUTPUT; i++) begin
                if (inc[i] && !dec[i])
                    cnt[i] <= cnt[i] + CW'(1);
                else if (dec[i] && !inc[i])
                    cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end

    assign clk_en = rst | (count != 2'd0) | any_cnt | slave_arvld;

endmodule

// File: tb/tb_ours_axi4_ar_demux_buf.sv
// tb_ours_axi4_ar_demux_buf: table-driven bench for the AR demux buffer.
// dut2 covers the 2-target cases, dut3 the 3-target select boundary.
module tb_ours_axi4_ar_demux_buf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, vld, srdy, cen;
    logic [31:0]      ar;
    logic [1:0]       mvld, mrdy, rdone;
    logic [1:0][31:0] mar;

    logic             rst3, vld3, srdy3, cen3;
    logic [31:0]      ar3;
    logic [2:0]       mvld3, mrdy3, rdone3;
    logic [2:0][31:0] mar3;

    int n_cmp = 0;
    int n_bad = 0;

    ours_axi4_ar_demux_buf #(
        .N_OUTPUT(2), .WIDTH(32), .SEL_POSITION(0), .MAX_OUTSTANDING(4)
    ) dut2 (
        .clk(clk), .rst(rst),
        .slave_arvld(vld), .slave_ar(ar), .slave_arrdy(srdy),
        .master_arvld(mvld), .master_ar(mar), .master_arrdy(mrdy),
        .r_done(rdone), .clk_en(cen)
    );

    ours_axi4_ar_demux_buf #(
        .N_OUTPUT(3), .WIDTH(32), .SEL_POSITION(4), .MAX_OUTSTANDING(4)
    ) dut3 (
        .clk(clk), .rst(rst3),
        .slave_arvld(vld3), .slave_ar(ar3), .slave_arrdy(srdy3),
        .master_arvld(mvld3), .master_ar(mar3), .master_arrdy(mrdy3),
        .r_done(rdone3), .clk_en(cen3)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] ar;
        logic [1:0]  mrdy;
        logic [1:0]  rdone;
        logic        srdy;
        logic [1:0]  mvld;
        logic [31:0] mar;
        logic        cen;
        logic [2:0]  c0;
        logic [2:0]  c1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        input logic r, input logic vl, input logic [31:0] a,
        input logic [1:0] rd, input logic [1:0] dn,
        input logic sr, input logic [1:0] mv, input logic [31:0] ma,
        input logic ce, input logic [2:0] c0, input logic [2:0] c1
    );
        vec_t t;
        t.rst = r; t.vld = vl; t.ar = a; t.mrdy = rd; t.rdone = dn;
        t.srdy = sr; t.mvld = mv; t.mar = ma; t.cen = ce;
        t.c0 = c0; t.c1 = c1;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; vld = 0; ar = '0; mrdy = '0; rdone = '0;
        rst3 = 1; vld3 = 0; ar3 = '0; mrdy3 = '0; rdone3 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst3 = 0;

        // reset, idle, single request to target 1
        tbl.push_back(v(1,0,32'h0,2'b00,2'b00, 0,2'b00,32'h0,1,0,0));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b00, 1,2'b00,32'h0,0,0,0));
        tbl.push_back(v(0,1,32'h1000_0001,2'b10,2'b00, 1,2'b00,32'h0,1,0,0));
        tbl.push_back(v(0,0,32'h0,2'b10,2'b00, 1,2'b10,32'h1000_0001,1,0,0));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b00, 1,2'b00,32'h0,1,0,1));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b10, 1,2'b00,32'h0,1,0,1));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b00, 1,2'b00,32'h0,0,0,0));
        // outstanding limit on target 0
        tbl.push_back(v(0,1,32'h10,2'b01,2'b00, 1,2'b00,32'h0,1,0,0));
        tbl.push_back(v(0,1,32'h20,2'b01,2'b00, 1,2'b01,32'h10,1,0,0));
        tbl.push_back(v(0,1,32'h30,2'b01,2'b00, 1,2'b01,32'h20,1,1,0));
        tbl.push_back(v(0,1,32'h40,2'b01,2'b00, 1,2'b01,32'h30,1,2,0));
        tbl.push_back(v(0,1,32'h50,2'b01,2'b00, 1,2'b01,32'h40,1,3,0));
        tbl.push_back(v(0,0,32'h0,2'b01,2'b00, 1,2'b00,32'h0,1,4,0));
        tbl.push_back(v(0,0,32'h0,2'b01,2'b00, 1,2'b00,32'h0,1,4,0));
        tbl.push_back(v(0,0,32'h0,2'b01,2'b01, 1,2'b01,32'h50,1,4,0));
        tbl.push_back(v(0,0,32'h0,2'b01,2'b00, 1,2'b00,32'h0,1,4,0));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b01, 1,2'b00,32'h0,1,4,0));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b01, 1,2'b00,32'h0,1,3,0));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b01, 1,2'b00,32'h0,1,2,0));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b01, 1,2'b00,32'h0,1,1,0));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b00, 1,2'b00,32'h0,0,0,0));
        // backpressure: third request stalls, nothing lost
        tbl.push_back(v(0,1,32'hC000_0001,2'b00,2'b00, 1,2'b00,32'h0,1,0,0));
        tbl.push_back(v(0,1,32'hC000_0003,2'b00,2'b00, 1,2'b10,32'hC000_0001,1,0,0));
        tbl.push_back(v(0,1,32'hC000_0005,2'b00,2'b00, 0,2'b10,32'hC000_0001,1,0,0));
        tbl.push_back(v(0,1,32'hC000_0005,2'b10,2'b00, 0,2'b10,32'hC000_0001,1,0,0));
        tbl.push_back(v(0,1,32'hC000_0005,2'b10,2'b00, 1,2'b10,32'hC000_0003,1,0,1));
        tbl.push_back(v(0,0,32'h0,2'b10,2'b00, 1,2'b10,32'hC000_0005,1,0,2));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b10, 1,2'b00,32'h0,1,0,3));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b10, 1,2'b00,32'h0,1,0,2));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b10, 1,2'b00,32'h0,1,0,1));
        // r_done on an idle target is ignored
        tbl.push_back(v(0,0,32'h0,2'b00,2'b01, 1,2'b00,32'h0,0,0,0));
        tbl.push_back(v(0,0,32'h0,2'b00,2'b00, 1,2'b00,32'h0,0,0,0));
        // mid-operation reset with two queued and cnt[0]=2
        tbl.push_back(v(0,1,32'hE000_0000,2'b01,2'b00, 1,2'b00,32'h0,1,0,0));
        tbl.push_back(v(0,1,32'hE000_0010,2'b01,2'b00, 1,2'b01,32'hE000_0000,1,0,0));
        tbl.push_back(v(0,1,32'hE000_0020,2'b01,2'b00, 1,2'b01,32'hE000_0010,1,1,0));
        tbl.push_back(v(0,1,32'hE000_0030,2'b00,2'b00, 1,2'b01,32'hE000_0020,1,2,0));
        tbl.push_back(v(1,1,32'hE000_0040,2'b01,2'b00, 0,2'b00,32'h0,1,2,0));
        tbl.push_back(v(0,0,32'h0,2'b01,2'b00, 1,2'b00,32'h0,0,0,0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; vld = tbl[i].vld; ar = tbl[i].ar;
            mrdy = tbl[i].mrdy; rdone = tbl[i].rdone;
            #3;
            chk($sformatf("r%0d srdy", i), srdy, tbl[i].srdy);
            chk($sformatf("r%0d mvld", i), mvld, tbl[i].mvld);
            chk($sformatf("r%0d clk_en", i), cen, tbl[i].cen);
            chk($sformatf("r%0d cnt0", i), dut2.cnt[0], tbl[i].c0);
            chk($sformatf("r%0d cnt1", i), dut2.cnt[1], tbl[i].c1);
            if (tbl[i].mvld != 2'b00)
                chk($sformatf("r%0d mar", i), mar, {2{tbl[i].mar}});
            tick();
        end

        // target 0 then target 1: ordering hold
        rst = 0; vld = 1; ar = 32'hF000_0000; mrdy = 2'b11; rdone = 2'b00;
        #3; chk("so_a mvld", mvld, 2'b00);
        tick();
        vld = 1; ar = 32'hF000_0001;
        #3; chk("so_b mvld", mvld, 2'b01);
        chk("so_b mar", mar, {2{32'hF000_0000}});
        tick();
        vld = 0;
`ifdef OURS_AXI4_AR_DEMUX_STRICT_ORDER_EN
        #3; chk("so_c mvld", mvld, 2'b00);
        chk("so_c cnt0", dut2.cnt[0], 3'd1);
        tick();
        rdone = 2'b01;
        #3; chk("so_d mvld", mvld, 2'b00);
        tick();
        rdone = 2'b00;
        #3; chk("so_e mvld", mvld, 2'b10);
        chk("so_e mar", mar, {2{32'hF000_0001}});
        chk("so_e cnt0", dut2.cnt[0], 3'd0);
        tick();
        rdone = 2'b10;
        #3; chk("so_f mvld", mvld, 2'b00);
        chk("so_f cnt1", dut2.cnt[1], 3'd1);
        tick();
`else
        #3; chk("so_c mvld", mvld, 2'b10);
        chk("so_c mar", mar, {2{32'hF000_0001}});
        chk("so_c cnt0", dut2.cnt[0], 3'd1);
        tick();
        rdone = 2'b01;
        #3; chk("so_d mvld", mvld, 2'b00);
        chk("so_d cnt1", dut2.cnt[1], 3'd1);
        tick();
        rdone = 2'b10;
        #3; chk("so_e cnt0", dut2.cnt[0], 3'd0);
        tick();
`endif
        rdone = 2'b00;
        #3; chk("so_end cnt0", dut2.cnt[0], 3'd0);
        chk("so_end cnt1", dut2.cnt[1], 3'd0);
        chk("so_end clk_en", cen, 1'b0);
        tick();

        // 3 targets: select 3 folds to output 2, idle r_done ignored
        vld3 = 1; ar3 = 32'h0000_0030; mrdy3 = 3'b100;
        #3; chk("b3_a mvld", mvld3, 3'b000);
        chk("b3_a srdy", srdy3, 1'b1);
        tick();
        vld3 = 0;
        #3; chk("b3_b mvld", mvld3, 3'b100);
        chk("b3_b mar", mar3, {3{32'h0000_0030}});
        tick();
        rdone3 = 3'b010;
        #3; chk("b3_c mvld", mvld3, 3'b000);
        chk("b3_c cnt2", dut3.cnt[2], 3'd1);
        chk("b3_c cnt1", dut3.cnt[1], 3'd0);
        tick();
        rdone3 = 3'b000; vld3 = 1; ar3 = 32'h0000_0025; mrdy3 = 3'b000;
        #3; chk("b3_d cnt1", dut3.cnt[1], 3'd0);
        tick();
        vld3 = 0; rdone3 = 3'b100;
        #3; chk("b3_e mvld", mvld3, 3'b100);
        chk("b3_e mar", mar3, {3{32'h0000_0025}});
        tick();
        rdone3 = 3'b000;
        #3; chk("b3_f cnt2", dut3.cnt[2], 3'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
